// File: rtl/bilinear_window_fetch.sv
// 2x2 neighbourhood fetcher with a two-row register cache (rows y0/y1), edge clamping,
// runtime image size and valid/ready output flow control.
module bilinear_window_fetch #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WIDTH = 64,
    parameter int RD_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       img_w,
    input  logic [15:0]       img_h,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       req_xi,
    input  logic [15:0]       req_yi,
    input  logic [7:0]        req_fx,
    input  logic [7:0]        req_fy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        pix_tl,
    output logic [7:0]        pix_tr,
    output logic [7:0]        pix_bl,
    output logic [7:0]        pix_br,
    output logic [7:0]        frac_x,
    output logic [7:0]        frac_y,
    output logic [ADDR_W-1:0] mem_raddr0,
    output logic [ADDR_W-1:0] mem_raddr1,
    input  logic [31:0]       mem_rdata0,
    input  logic [31:0]       mem_rdata1,
    output logic [15:0]       miss_count
);
    localparam int DEPTH = MAX_WIDTH / 4;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {SERVE, LOAD} state_t;
    state_t state, state_nxt;

    logic [31:0]    row_t [DEPTH];
    logic [31:0]    row_b [DEPTH];
    logic           cache_valid;
    logic [15:0]    cached_y, load_y, issue_cnt;
    logic [RD_LAT:1] vld_pipe;
    logic [IW-1:0]  idx_pipe [1:RD_LAT];

    logic [15:0]       wpl, x0, x1, y0, ly1;
    logic [ADDR_W-1:0] off0, off1;
    logic              hit, accept, start_load, issue_v, wr_en, last_wr;
    logic [31:0]       wt0, wt1, wb0, wb1;

    function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] b);
        return w[{b, 3'b000} +: 8];
    endfunction

    assign wpl  = (img_w + 16'd3) >> 2;
    assign x0   = (req_xi < img_w) ? req_xi : img_w - 16'd1;
    assign x1   = (x0 + 16'd1 < img_w) ? x0 + 16'd1 : img_w - 16'd1;
    assign y0   = (req_yi < img_h) ? req_yi : img_h - 16'd1;
    assign ly1  = (load_y + 16'd1 < img_h) ? load_y + 16'd1 : img_h - 16'd1;
    assign off0 = ADDR_W'(32'(load_y) * 32'(wpl));
    assign off1 = ADDR_W'(32'(ly1) * 32'(wpl));

    assign hit        = cache_valid && (y0 == cached_y);
    assign req_ready  = (state == SERVE) && hit && !flush && (!out_valid || out_ready);
    assign accept     = req_valid && req_ready;
    assign start_load = (state == SERVE) && req_valid && !hit && !flush;
    assign issue_v    = (state == LOAD) && !flush && (issue_cnt < wpl);
    assign wr_en      = (state == LOAD) && !flush && vld_pipe[RD_LAT];
    assign last_wr    = wr_en && (idx_pipe[RD_LAT] == IW'(wpl - 16'd1));

    assign wt0 = row_t[x0[IW+1:2]];
    assign wt1 = row_t[x1[IW+1:2]];
    assign wb0 = row_b[x0[IW+1:2]];
    assign wb1 = row_b[x1[IW+1:2]];

    wire unused_bits = &{1'b0, x0[15:IW+2], x1[15:IW+2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SERVE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SERVE: if (start_load)       state_nxt = LOAD;
            LOAD:  if (flush || last_wr) state_nxt = SERVE;
            default:                     state_nxt = SERVE;
        endcase
    end

    // Returned words are matched to their index by the latency-deep valid/index pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int s = 1; s <= RD_LAT; s++) idx_pipe[s] <= '0;
        end else begin
            for (int s = RD_LAT; s > 1; s--) begin
                vld_pipe[s] <= vld_pipe[s-1];
                idx_pipe[s] <= idx_pipe[s-1];
            end
            vld_pipe[1] <= issue_v;
            idx_pipe[1] <= IW'(issue_cnt);
            if (flush) vld_pipe <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            row_t[idx_pipe[RD_LAT]] <= mem_rdata0;
            row_b[idx_pipe[RD_LAT]] <= mem_rdata1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
            cached_y    <= '0;
            load_y      <= '0;
            issue_cnt   <= '0;
            mem_raddr0  <= '0;
            mem_raddr1  <= '0;
            miss_count  <= '0;
            out_valid   <= 1'b0;
            pix_tl      <= '0;
            pix_tr      <= '0;
            pix_bl      <= '0;
            pix_br      <= '0;
            frac_x      <= '0;
            frac_y      <= '0;
        end else begin
            if (start_load) begin
                load_y      <= y0;
                issue_cnt   <= '0;
                cache_valid <= 1'b0;
            end
            if (issue_v) begin
                mem_raddr0 <= frame_base + off0 + ADDR_W'(issue_cnt);
                mem_raddr1 <= frame_base + off1 + ADDR_W'(issue_cnt);
                issue_cnt  <= issue_cnt + 16'd1;
            end
            if (last_wr) begin
                cached_y    <= load_y;
                cache_valid <= 1'b1;
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
            if (flush) cache_valid <= 1'b0;

            if (accept) begin
                out_valid <= 1'b1;
                pix_tl    <= pick(wt0, x0[1:0]);
                pix_tr    <= pick(wt1, x1[1:0]);
                pix_bl    <= pick(wb0, x0[1:0]);
                pix_br    <= pick(wb1, x1[1:0]);
                frac_x    <= req_fx;
                frac_y    <= req_fy;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bilinear_window_fetch.sv
// Bench for bilinear_window_fetch: pattern-image memory, clamping/pixel model with an
// in-order expected-result queue, plus literal timing and pixel checks.
module tb_bilinear_window_fetch;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       img_w = 16'd16, img_h = 16'd16;
    logic [ADDR_W-1:0] frame_base = '0;
    logic              flush = 1'b0, req_valid = 1'b0, out_ready = 1'b1;
    logic              req_ready, out_valid;
    logic [15:0]       req_xi = '0, req_yi = '0;
    logic [7:0]        req_fx = '0, req_fy = '0;
    logic [7:0]        pix_tl, pix_tr, pix_bl, pix_br, frac_x, frac_y;
    logic [ADDR_W-1:0] mem_raddr0, mem_raddr1, a0_d, a1_d;
    logic [31:0]       mem_rdata0, mem_rdata1;
    logic [15:0]       miss_count;

    always #5 clk = ~clk;

    bilinear_window_fetch #(.ADDR_W(ADDR_W), .MAX_WIDTH(64), .RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .img_w(img_w), .img_h(img_h), .frame_base(frame_base),
        .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .req_xi(req_xi), .req_yi(req_yi), .req_fx(req_fx), .req_fy(req_fy),
        .out_valid(out_valid), .out_ready(out_ready),
        .pix_tl(pix_tl), .pix_tr(pix_tr), .pix_bl(pix_bl), .pix_br(pix_br),
        .frac_x(frac_x), .frac_y(frac_y), .mem_raddr0(mem_raddr0), .mem_raddr1(mem_raddr1),
        .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1), .miss_count(miss_count)
    );

    // Image memory with two-cycle read latency: address registered at edge k, data sampled at k+2.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        a0_d <= mem_raddr0;
        a1_d <= mem_raddr1;
    end
    assign mem_rdata0 = mem[a0_d];
    assign mem_rdata1 = mem[a1_d];

    typedef struct packed { logic [7:0] tl, tr, bl, br, fx, fy; } res_t;
    res_t exp_q[$];
    int   n_cmp = 0, n_err = 0, cyc = 0, cur_w = 16, cur_h = 16;
    bit   tog_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pix(int x, int y);
        return 8'((16 * y + x) & 255);
    endfunction

    function automatic res_t model(int xi, int yi, logic [7:0] fx, logic [7:0] fy);
        int x0, x1, y0, y1;
        x0 = (xi > cur_w - 1) ? cur_w - 1 : xi;
        y0 = (yi > cur_h - 1) ? cur_h - 1 : yi;
        x1 = (x0 + 1 > cur_w - 1) ? cur_w - 1 : x0 + 1;
        y1 = (y0 + 1 > cur_h - 1) ? cur_h - 1 : y0 + 1;
        return {pix(x0, y0), pix(x1, y0), pix(x0, y1), pix(x1, y1), fx, fy};
    endfunction

    task automatic fill_mem(int w, int h);
        int wpl;
        wpl = (w + 3) / 4;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                mem[y * wpl + x / 4][8 * (x % 4) +: 8] = pix(x, y);
    endtask

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog_en) out_ready = ~out_ready;
    endtask

    task automatic start_req(int x, int y, logic [7:0] fx, logic [7:0] fy);
        req_valid = 1'b1;
        req_xi = 16'(x); req_yi = 16'(y); req_fx = fx; req_fy = fy;
        exp_q.push_back(model(x, y, fx, fy));
    endtask

    task automatic wait_acc(output int acyc);
        bit ok, rdy;
        ok = 1'b0;
        acyc = cyc;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rdy = req_ready;
            tick();
            if (rdy) begin
                acyc = cyc;
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: request (%0d,%0d) never accepted", req_xi, req_yi);
        end
    endtask

    task automatic send(int x, int y, logic [7:0] fx, logic [7:0] fy, output int lat);
        int c0, a;
        c0 = cyc;
        start_req(x, y, fx, fy);
        wait_acc(a);
        lat = a - c0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
    endtask

    // Every consumed result must be the next expected one, in order.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL result_order: got extra result %h%h%h%h expected none",
                         pix_tl, pix_tr, pix_bl, pix_br);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                if ({pix_tl, pix_tr, pix_bl, pix_br, frac_x, frac_y} !== e) begin
                    n_err++;
                    $display("FAIL result_model: got %h expected %h",
                             {pix_tl, pix_tr, pix_bl, pix_br, frac_x, frac_y}, e);
                end
            end
        end
    end

    initial begin
        int lat, c0, a, mc;
        fill_mem(16, 16);
        #12;
        chk("reset_outputs", {out_valid, req_ready, pix_tl, pix_tr, pix_bl, pix_br, frac_x, frac_y,
                              mem_raddr0, mem_raddr1, miss_count}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        send(5, 3, 8'h40, 8'h80, lat);
        chk("miss_latency", lat, 8);
        chk("pix_5_3", {pix_tl, pix_tr, pix_bl, pix_br}, 32'h35364546);
        chk("frac_5_3", {frac_x, frac_y}, 16'h4080);
        chk("miss_count_1", miss_count, 1);

        send(7, 3, 8'h11, 8'h22, lat);
        chk("hit_latency", lat, 1);
        chk("pix_7_3", {pix_tl, pix_tr, pix_bl, pix_br}, 32'h37384748);
        chk("miss_count_hit", miss_count, 1);

        send(15, 15, 8'h01, 8'h02, lat);
        chk("pix_15_15", {pix_tl, pix_tr, pix_bl, pix_br}, 32'hFFFFFFFF);
        send(20, 2, 8'h03, 8'h04, lat);
        chk("pix_20_2", {pix_tl, pix_tr, pix_bl, pix_br}, 32'h2F2F3F3F);
        chk("miss_count_3", miss_count, 3);

        tick();
        c0 = cyc;
        for (int x = 0; x < 16; x++) send(x, 5, 8'(x * 16), 8'(255 - x), lat);
        chk("stream_cycles", cyc - c0, 23);
        chk("miss_count_stream", miss_count, 4);

        tog_en = 1'b1;
        for (int x = 0; x < 16; x++) send(x, 6, 8'(x), 8'(x + 100), lat);
        drain();
        tog_en = 1'b0;
        out_ready = 1'b1;
        chk("toggle_drained", exp_q.size(), 0);
        chk("miss_count_toggle", miss_count, 5);

        tick();
        start_req(3, 10, 8'h05, 8'h06);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        c0 = cyc;
        wait_acc(a);
        chk("flush_reload_latency", a - c0, 8);
        chk("miss_count_flush", miss_count, 6);

        tick();
        img_w = 16'd10; cur_w = 10;
        fill_mem(10, 16);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        c0 = cyc;
        start_req(9, 0, 8'h07, 8'h08);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("addr_w10", {mem_raddr0, mem_raddr1}, {10'(i), 10'(i + 3)});
        end
        wait_acc(a);
        chk("w10_latency", a - c0, 7);
        chk("pix_w10", {pix_tl, pix_tr, pix_bl, pix_br}, 32'h09091919);
        mc = miss_count;
        chk("miss_count_w10", mc, 7);

        tick();
        tick();
        req_valid = 1'b1; req_xi = 16'd2; req_yi = 16'd7;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_load", {out_valid, req_ready, pix_tl, pix_tr, pix_bl, pix_br, frac_x, frac_y,
                               mem_raddr0, mem_raddr1, miss_count}, '0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(2, 7, 8'h09, 8'h0A, lat);
        chk("post_reset_miss_latency", lat, 7);
        chk("miss_count_post_reset", miss_count, 1);

        tick();
        drain();
        chk("final_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
